btb_update_ctrl: RTL and testbench



---
 rtl/btb_pkg.sv | 23 ++
 rtl/btb_update_ctrl_if.sv | 35 +++
 rtl/btb_upd_fifo.sv | 64 ++++++
 rtl/btb_update_ctrl.sv | 153 +++++++++++++++
 tb/tb_btb_update_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/btb_pkg.sv
// Shared BTB definitions: geometry constants, the update record carried
// from ID-stage resolution to the BTB write port, and the sequencer state type.
package btb_pkg;

    localparam int BTB_NUM_LINES = 32;
    localparam int BTB_TAG_W     = 9;
    localparam int BTB_SET_W     = 4;
    localparam int BTB_PC_W      = 13;

    typedef struct packed {
        logic [BTB_PC_W-1:0] pc;
        logic [31:0]         imm;
        logic                branch;
    } btb_rec_t;

    localparam int BTB_REC_W = $bits(btb_rec_t);

    typedef enum logic [0:0] {
        BTB_ST_RUN   = 1'b0,
        BTB_ST_FLUSH = 1'b1
    } btb_state_e;

endpackage

// File: rtl/btb_update_ctrl_if.sv
// Bundle between ID-stage resolution, the update sequencer and the BTB write port.
// master = surrounding pipeline/BTB, slave = btb_update_ctrl.
interface btb_update_ctrl_if #(
    parameter int PC_W   = 13,
    parameter int LINE_W = 5
);
    logic              upd_valid;
    logic              upd_ready;
    logic [PC_W-1:0]   upd_pc;
    logic [31:0]       upd_imm;
    logic              upd_branch;
    logic              flush_req;
    logic              btb_hold;
    logic              btb_write;
    logic [PC_W-1:0]   btb_pc;
    logic [31:0]       btb_imm;
    logic              btb_branch;
    logic              btb_inval;
    logic [LINE_W-1:0] btb_line;
    logic              flush_busy;
    logic              flush_done;

    modport master (
        output upd_valid, upd_pc, upd_imm, upd_branch, flush_req, btb_hold,
        input  upd_ready, btb_write, btb_pc, btb_imm, btb_branch,
        input  btb_inval, btb_line, flush_busy, flush_done
    );

    modport slave (
        input  upd_valid, upd_pc, upd_imm, upd_branch, flush_req, btb_hold,
        output upd_ready, btb_write, btb_pc, btb_imm, btb_branch,
        output btb_inval, btb_line, flush_busy, flush_done
    );

endinterface

// File: rtl/btb_upd_fifo.sv
// Synchronous FIFO of BTB update records; clear wins over push and pop.
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  btb_rec_t               push_data_i,
    input  logic                   pop_i,
    output btb_rec_t               pop_data_o,
    input  logic                   clear_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    btb_rec_t      mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign do_push_s  = push_i && !full_o;
    assign do_pop_s   = pop_i && !empty_o;

    // Storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write-port sequencer: drains queued branch resolutions one per cycle
// and walks every line for invalidation on flush requests and after reset.
module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int NUM_LINES  = BTB_NUM_LINES,
    parameter int PC_W       = BTB_PC_W,
    parameter bit INIT_FLUSH = 1'b1
) (
    input logic              clk,
    input logic              rst,
    btb_update_ctrl_if.slave bus
);

    localparam logic [0:0] ST_RUN   = 1'(BTB_ST_RUN);
    localparam logic [0:0] ST_FLUSH = 1'(BTB_ST_FLUSH);
    localparam int         LINE_W   = $clog2(NUM_LINES);
    localparam int         CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(NUM_LINES - 1);

    logic [0:0]        state_q, state_d;
    logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
    logic              btb_write_q, btb_write_d;
    logic [PC_W-1:0]   btb_pc_q, btb_pc_d;
    logic [31:0]       btb_imm_q, btb_imm_d;
    logic              btb_branch_q, btb_branch_d;
    logic              btb_inval_q, btb_inval_d;
    logic [LINE_W-1:0] btb_line_q, btb_line_d;
    logic              flush_done_q, flush_done_d;

    btb_rec_t          push_rec_s;
    btb_rec_t          head_rec_s;
    logic              upd_ready_s;
    logic              fifo_push_s, fifo_pop_s, fifo_clear_s;
    logic              fifo_full_s, fifo_empty_s;
    logic [CNT_W-1:0]  fifo_count_s;

    // A flush request in the same cycle drops the offered record.
    assign upd_ready_s = (state_q == ST_RUN) && (fifo_count_s < CNT_W'(DEPTH)) && !bus.flush_req;
    assign fifo_push_s = bus.upd_valid && upd_ready_s && !fifo_full_s;

    // Pack the incoming resolution into a FIFO record
    always_comb begin
        push_rec_s        = '0;
        push_rec_s.pc     = bus.upd_pc;
        push_rec_s.imm    = bus.upd_imm;
        push_rec_s.branch = bus.upd_branch;
    end

    btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push_s),
        .push_data_i (push_rec_s),
        .pop_i       (fifo_pop_s),
        .pop_data_o  (head_rec_s),
        .clear_i     (fifo_clear_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .count_o     (fifo_count_s)
    );

    // Next-state: drain in RUN, invalidation walk in FLUSH
    always_comb begin
        state_d      = state_q;
        line_cnt_d   = line_cnt_q;
        btb_write_d  = 1'b0;
        btb_pc_d     = btb_pc_q;
        btb_imm_d    = btb_imm_q;
        btb_branch_d = btb_branch_q;
        btb_inval_d  = 1'b0;
        btb_line_d   = btb_line_q;
        flush_done_d = 1'b0;
        fifo_pop_s   = 1'b0;
        fifo_clear_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.flush_req) begin
                    state_d      = ST_FLUSH;
                    line_cnt_d   = '0;
                    fifo_clear_s = 1'b1;
                end else if (!fifo_empty_s && !bus.btb_hold) begin
                    fifo_pop_s   = 1'b1;
                    btb_write_d  = 1'b1;
                    btb_pc_d     = head_rec_s.pc;
                    btb_imm_d    = head_rec_s.imm;
                    btb_branch_d = head_rec_s.branch;
                end else begin
                    fifo_pop_s = 1'b0;
                end
            end
            ST_FLUSH: begin
                // A repeated request restarts the walk and silences this cycle's command.
                if (bus.flush_req) begin
                    line_cnt_d = '0;
                end else if (!bus.btb_hold) begin
                    btb_inval_d = 1'b1;
                    btb_line_d  = line_cnt_q;
                    line_cnt_d  = line_cnt_q + LINE_W'(1);
                    if (line_cnt_q == LAST_LINE) begin
                        state_d      = ST_RUN;
                        flush_done_d = 1'b1;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end else begin
                    line_cnt_d = line_cnt_q;
                end
            end
            default: begin
                state_d    = ST_RUN;
                line_cnt_d = '0;
            end
        endcase
    end

    // State, counter and registered BTB command outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= INIT_FLUSH ? ST_FLUSH : ST_RUN;
            line_cnt_q   <= '0;
            btb_write_q  <= 1'b0;
            btb_pc_q     <= '0;
            btb_imm_q    <= 32'h0000_0000;
            btb_branch_q <= 1'b0;
            btb_inval_q  <= 1'b0;
            btb_line_q   <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_cnt_q   <= line_cnt_d;
            btb_write_q  <= btb_write_d;
            btb_pc_q     <= btb_pc_d;
            btb_imm_q    <= btb_imm_d;
            btb_branch_q <= btb_branch_d;
            btb_inval_q  <= btb_inval_d;
            btb_line_q   <= btb_line_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign bus.upd_ready  = upd_ready_s;
    assign bus.btb_write  = btb_write_q;
    assign bus.btb_pc     = btb_pc_q;
    assign bus.btb_imm    = btb_imm_q;
    assign bus.btb_branch = btb_branch_q;
    assign bus.btb_inval  = btb_inval_q;
    assign bus.btb_line   = btb_line_q;
    assign bus.flush_busy = (state_q == ST_FLUSH);
    assign bus.flush_done = flush_done_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: queue-based reference model checked every
// cycle, plus literal expectations on write/invalidate sequences and reset.
module tb_btb_update_ctrl;
    import btb_pkg::*;

    logic clk = 1'b0;
    logic rst1;
    logic rst0;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    btb_update_ctrl_if #(.PC_W(13), .LINE_W(5)) bus1 ();
    btb_update_ctrl_if #(.PC_W(13), .LINE_W(5)) bus0 ();

    btb_update_ctrl #(.DEPTH(4), .NUM_LINES(32), .PC_W(13), .INIT_FLUSH(1'b1)) dut1 (
        .clk (clk), .rst (rst1), .bus (bus1)
    );
    btb_update_ctrl #(.DEPTH(4), .NUM_LINES(32), .PC_W(13), .INIT_FLUSH(1'b0)) dut0 (
        .clk (clk), .rst (rst0), .bus (bus0)
    );

    always #5 clk = ~clk;

    // reference model state (abstract: mode flag, record queue, walk index)
    int         m_mode;
    int         m_line;
    btb_rec_t   m_q[$];
    logic       e_write, e_inval, e_done, e_branch;
    logic [12:0] e_pc;
    logic [31:0] e_imm;
    logic [4:0]  e_line;

    // observation logs for dut1
    logic [12:0] wr_log[$];
    int          wr_cyc[$];
    int          inv_log[$];
    int          inv_cyc[$];
    int          done_cnt;
    int          done_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic model_ready();
        return (m_mode == 0) && (m_q.size() < 4) && !bus1.flush_req;
    endfunction

    task automatic model_step();
        logic     acc;
        btb_rec_t r;
        if (rst1) begin
            m_mode = 1; m_line = 0; m_q.delete();
            e_write = 1'b0; e_inval = 1'b0; e_done = 1'b0;
            return;
        end
        acc = bus1.upd_valid && model_ready();
        e_write = 1'b0; e_inval = 1'b0; e_done = 1'b0;
        if (m_mode == 0) begin
            if (bus1.flush_req) begin
                m_mode = 1; m_line = 0; m_q.delete();
            end else begin
                if (m_q.size() > 0 && !bus1.btb_hold) begin
                    r = m_q.pop_front();
                    e_write = 1'b1; e_pc = r.pc; e_imm = r.imm; e_branch = r.branch;
                end
                if (acc) begin
                    r.pc = bus1.upd_pc; r.imm = bus1.upd_imm; r.branch = bus1.upd_branch;
                    m_q.push_back(r);
                end
            end
        end else begin
            if (bus1.flush_req) begin
                m_line = 0;
            end else if (!bus1.btb_hold) begin
                e_inval = 1'b1; e_line = 5'(m_line);
                m_line++;
                if (m_line == 32) begin
                    m_line = 0; m_mode = 0; e_done = 1'b1;
                end
            end
        end
    endtask

    // per-cycle compare of dut1 against the model, and logging
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            #1;
            check("write", 64'(bus1.btb_write), 64'(e_write));
            if (e_write) begin
                check("pc", 64'(bus1.btb_pc), 64'(e_pc));
                check("imm", 64'(bus1.btb_imm), 64'(e_imm));
                check("branch", 64'(bus1.btb_branch), 64'(e_branch));
            end
            check("inval", 64'(bus1.btb_inval), 64'(e_inval));
            if (e_inval) check("line", 64'(bus1.btb_line), 64'(e_line));
            check("done", 64'(bus1.flush_done), 64'(e_done));
            check("busy", 64'(bus1.flush_busy), 64'(m_mode == 1));
            check("ready", 64'(bus1.upd_ready), 64'(model_ready()));
            if (bus1.btb_write) begin wr_log.push_back(bus1.btb_pc); wr_cyc.push_back(cyc); end
            if (bus1.btb_inval) begin inv_log.push_back(int'(bus1.btb_line)); inv_cyc.push_back(cyc); end
            if (bus1.flush_done) begin done_cnt++; done_cyc = cyc; end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        wr_log.delete(); wr_cyc.delete(); inv_log.delete(); inv_cyc.delete();
        done_cnt = 0; done_cyc = -1;
    endtask

    task automatic offer(input logic [12:0] pc);
        bus1.upd_valid  = 1'b1;
        bus1.upd_pc     = pc;
        bus1.upd_imm    = 32'h8000_0000 | 32'(pc);
        bus1.upd_branch = pc[4];
        @(negedge clk);
        bus1.upd_valid  = 1'b0;
    endtask

    task automatic offer0(input logic [12:0] pc);
        bus0.upd_valid  = 1'b1;
        bus0.upd_pc     = pc;
        bus0.upd_imm    = 32'h4000_0000 | 32'(pc);
        bus0.upd_branch = 1'b1;
        @(negedge clk);
        bus0.upd_valid  = 1'b0;
    endtask

    task automatic check_walk(input string name, input int base);
        check({name, "_cnt"}, 64'(inv_log.size()), 64'(base + 32));
        for (int i = 0; i < 32; i++) begin
            check({name, "_seq"}, 64'(inv_log[base + i]), 64'(i));
        end
        check({name, "_consec"}, 64'(inv_cyc[base + 31] - inv_cyc[base]), 64'd31);
        check({name, "_done1"}, 64'(done_cnt), 64'd1);
        check({name, "_done_at31"}, 64'(done_cyc), 64'(inv_cyc[base + 31]));
    endtask

    initial begin
        int c0;
        rst1 = 1'b1; rst0 = 1'b1;
        bus1.upd_valid = 1'b0; bus1.upd_pc = 13'h0; bus1.upd_imm = 32'h0; bus1.upd_branch = 1'b0;
        bus1.flush_req = 1'b0; bus1.btb_hold = 1'b0;
        bus0.upd_valid = 1'b0; bus0.upd_pc = 13'h0; bus0.upd_imm = 32'h0; bus0.upd_branch = 1'b0;
        bus0.flush_req = 1'b0; bus0.btb_hold = 1'b0;
        clear_logs();
        tick(3);
        check("rst_write", 64'(bus1.btb_write), 64'd0);
        check("rst_inval", 64'(bus1.btb_inval), 64'd0);
        check("rst_ready", 64'(bus1.upd_ready), 64'd0);

        // init walk after reset release
        rst1 = 1'b0;
        tick(10);
        check("walk_ready_low", 64'(bus1.upd_ready), 64'd0);
        check("walk_busy", 64'(bus1.flush_busy), 64'd1);
        tick(24);
        check_walk("init", 0);
        check("post_walk_ready", 64'(bus1.upd_ready), 64'd1);

        // four back-to-back records, no hold
        clear_logs();
        c0 = cyc;
        offer(13'h010); offer(13'h020); offer(13'h030); offer(13'h040);
        tick(3);
        check("b2b_cnt", 64'(wr_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("b2b_pc", 64'(wr_log[i]), 64'(16 * (i + 1)));
            check("b2b_cyc", 64'(wr_cyc[i]), 64'(c0 + 2 + i));
        end

        // fill the FIFO under hold; a fifth offer must be refused
        clear_logs();
        bus1.btb_hold = 1'b1;
        offer(13'h110); offer(13'h120); offer(13'h130); offer(13'h140);
        bus1.upd_valid = 1'b1; bus1.upd_pc = 13'h150; bus1.upd_imm = 32'h8000_0150; bus1.upd_branch = 1'b1;
        #1;
        check("full_ready", 64'(bus1.upd_ready), 64'd0);
        @(negedge clk);
        bus1.upd_valid = 1'b0; bus1.btb_hold = 1'b0;
        tick(6);
        check("full_cnt", 64'(wr_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) check("full_pc", 64'(wr_log[i]), 64'(13'h110 + 13'(16 * i)));

        // hold for three cycles with two queued records
        clear_logs();
        bus1.btb_hold = 1'b1;
        offer(13'h210); offer(13'h220);
        tick(1);
        check("hold_nowrite", 64'(wr_log.size()), 64'd0);
        bus1.btb_hold = 1'b0;
        tick(4);
        check("hold_cnt", 64'(wr_log.size()), 64'd2);
        check("hold_pc0", 64'(wr_log[0]), 64'h210);
        check("hold_pc1", 64'(wr_log[1]), 64'h220);

        // flush with three records queued and a fourth offered alongside
        clear_logs();
        bus1.btb_hold = 1'b1;
        offer(13'h310); offer(13'h320); offer(13'h330);
        bus1.btb_hold = 1'b0; bus1.flush_req = 1'b1;
        bus1.upd_valid = 1'b1; bus1.upd_pc = 13'h340; bus1.upd_imm = 32'h8000_0340;
        #1;
        check("flush_ready", 64'(bus1.upd_ready), 64'd0);
        @(negedge clk);
        bus1.flush_req = 1'b0; bus1.upd_valid = 1'b0;
        tick(34);
        check_walk("flushq", 0);
        tick(3);
        check("flushq_nowrite", 64'(wr_log.size()), 64'd0);

        // restart a walk at line 17
        clear_logs();
        bus1.flush_req = 1'b1;
        tick(1);
        bus1.flush_req = 1'b0;
        tick(17);
        check("abort_pre", 64'(inv_log.size()), 64'd17);
        bus1.flush_req = 1'b1;
        tick(1);
        bus1.flush_req = 1'b0;
        tick(34);
        check_walk("abort", 17);

        // INIT_FLUSH = 0 instance: reset mid-drain
        rst0 = 1'b0;
        #1;
        check("i0_ready", 64'(bus0.upd_ready), 64'd1);
        check("i0_busy", 64'(bus0.flush_busy), 64'd0);
        bus0.btb_hold = 1'b1;
        offer0(13'h410); offer0(13'h420); offer0(13'h430);
        bus0.btb_hold = 1'b0;
        @(negedge clk);
        #1;
        check("i0_write", 64'(bus0.btb_write), 64'd1);
        check("i0_pc", 64'(bus0.btb_pc), 64'h410);
        rst0 = 1'b1;
        #1;
        check("i0_rst_write", 64'(bus0.btb_write), 64'd0);
        check("i0_rst_pc", 64'(bus0.btb_pc), 64'd0);
        check("i0_rst_imm", 64'(bus0.btb_imm), 64'd0);
        check("i0_rst_inval", 64'(bus0.btb_inval), 64'd0);
        check("i0_rst_done", 64'(bus0.flush_done), 64'd0);
        check("i0_rst_busy", 64'(bus0.flush_busy), 64'd0);
        tick(2);
        rst0 = 1'b0;
        #1;
        check("i0_rel_ready", 64'(bus0.upd_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("i0_empty", 64'(bus0.btb_write), 64'd0);
            check("i0_noflush", 64'(bus0.btb_inval), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
